// File: rtl/postproc_pack_pkg.sv
`default_nettype none
// ============================================================================
// Module      : postproc_pack_pkg
// Description : Shared constants and helpers for the requantize-and-pack
//               stage: internal arithmetic width, int8 saturation bounds,
//               leaky-ReLU shift and default interface widths.
// Revision    : 1.0 - initial release
// ============================================================================
package postproc_pack_pkg;

    // All intermediate arithmetic is carried at this signed width so that
    // acc + bias + rounding term can never wrap.
    localparam int PP_W            = 34;
    localparam int LANE_W          = 8;

    localparam int PP_SAT_MAX      = 127;
    localparam int PP_SAT_MIN      = -128;
    localparam int PP_LEAKY_SHIFT  = 3;

    localparam int OFM_DW_DEF       = 32;
    localparam int FM_BUFFER_AW_DEF = 12;
    localparam int W_FRAME_SIZE_DEF = 16;

    localparam logic signed [PP_W-1:0] SAT_MAX_W = PP_W'(PP_SAT_MAX);
    localparam logic signed [PP_W-1:0] SAT_MIN_W = PP_W'(PP_SAT_MIN);

    // Clamp a wide signed value to int8 and return its two's-complement byte.
    function automatic logic [LANE_W-1:0] sat8(input logic signed [PP_W-1:0] v);
        logic [LANE_W-1:0] res;
        if (v > SAT_MAX_W) begin
            res = LANE_W'(PP_SAT_MAX);
        end else if (v < SAT_MIN_W) begin
            res = LANE_W'(PP_SAT_MIN);
        end else begin
            res = v[LANE_W-1:0];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pp_requant.sv
`default_nettype none
// ============================================================================
// Module      : pp_requant
// Description : Three-stage requantization pipeline with valid/last sideband.
//               S1: bias add; S2: optional leaky-ReLU and rounding offset;
//               S3: arithmetic right shift and int8 saturation.
// Ports       : clk/rstn      - clock, async active-low reset
//               clr           - synchronous flush of all stage valids
//               shift, act_en - quantization parameters (stable per layer)
//               in_*          - one accumulator value per cycle
//               out_*         - int8 result, 3 cycles after in_vld
// Revision    : 1.0 - initial release
// ============================================================================
module pp_requant
    import postproc_pack_pkg::*;
#(
    parameter int ACC_W  = 32,
    parameter int BIAS_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                clr,
    input  logic [4:0]          shift,
    input  logic                act_en,
    input  logic                in_vld,
    input  logic [ACC_W-1:0]    in_data,
    input  logic [BIAS_W-1:0]   in_bias,
    input  logic                in_last,
    output logic                out_vld,
    output logic [LANE_W-1:0]   out_data,
    output logic                out_last
);

    logic signed [PP_W-1:0] s1_sum;
    logic                   s1_vld, s1_last;
    logic signed [PP_W-1:0] s2_t;
    logic                   s2_vld, s2_last;

    logic signed [PP_W-1:0] acc_ext, bias_ext, act_val, rnd_val, shr_val;

    assign acc_ext  = {{(PP_W-ACC_W){in_data[ACC_W-1]}}, in_data};
    assign bias_ext = {{(PP_W-BIAS_W){in_bias[BIAS_W-1]}}, in_bias};

    // Leaky slope of 1/8 on negatives; >>> floors toward minus infinity.
    assign act_val  = (act_en && s1_sum[PP_W-1]) ? (s1_sum >>> PP_LEAKY_SHIFT) : s1_sum;
    // Round-half-up: add half an LSB of the post-shift result.
    assign rnd_val  = (shift != 5'd0) ? ({{(PP_W-1){1'b0}}, 1'b1} << (shift - 5'd1)) : '0;
    assign shr_val  = s2_t >>> shift;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_sum   <= '0;
            s1_vld   <= 1'b0;
            s1_last  <= 1'b0;
            s2_t     <= '0;
            s2_vld   <= 1'b0;
            s2_last  <= 1'b0;
            out_data <= '0;
            out_vld  <= 1'b0;
            out_last <= 1'b0;
        end else begin
            s1_sum   <= acc_ext + bias_ext;
            s1_last  <= in_last;
            s2_t     <= act_val + rnd_val;
            s2_last  <= s1_last;
            out_data <= sat8(shr_val);
            out_last <= s2_last;
            if (clr) begin
                s1_vld  <= 1'b0;
                s2_vld  <= 1'b0;
                out_vld <= 1'b0;
            end else begin
                s1_vld  <= in_vld;
                s2_vld  <= s1_vld;
                out_vld <= s2_vld;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/postproc_pack.sv
`default_nettype none
// ============================================================================
// Module      : postproc_pack
// Description : Requantize-and-pack stage. Bias add, optional leaky-ReLU,
//               round/shift/saturate to int8, then packs four results per
//               32-bit word for the route buffer / OFM write path.
// Ports       : clk/rstn            - clock, async active-low reset
//               q_layer_start       - pulse: flush pipeline, counters, done
//               q_frame_size        - words in the layer (>=1)
//               q_shift, q_act_en   - quantization parameters
//               acc_vld/data/bias/last - accumulator input stream
//               pp_data_vld/data/addr  - packed word output (pulse)
//               pp_done             - level, set with the final word
// Revision    : 1.0 - initial release
// ============================================================================
module postproc_pack
    import postproc_pack_pkg::*;
#(
    parameter int ACC_W        = 32,
    parameter int BIAS_W       = 16,
    parameter int OFM_DW       = OFM_DW_DEF,
    parameter int OFM_AW       = FM_BUFFER_AW_DEF,
    parameter int W_FRAME_SIZE = W_FRAME_SIZE_DEF
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    q_layer_start,
    input  logic [W_FRAME_SIZE-1:0] q_frame_size,
    input  logic [4:0]              q_shift,
    input  logic                    q_act_en,
    input  logic                    acc_vld,
    input  logic [ACC_W-1:0]        acc_data,
    input  logic [BIAS_W-1:0]       acc_bias,
    input  logic                    acc_last,
    output logic                    pp_data_vld,
    output logic [OFM_DW-1:0]       pp_data,
    output logic [OFM_AW-1:0]       pp_addr,
    output logic                    pp_done
);

    logic                    in_vld;
    logic                    rq_vld, rq_last;
    logic [LANE_W-1:0]       rq_data;

    logic [OFM_DW-1:0]       lane_reg;
    logic [1:0]              lane_cnt;
    logic [OFM_AW-1:0]       word_cnt;
    logic [W_FRAME_SIZE-1:0] frame_cnt;
    logic [W_FRAME_SIZE-1:0] frame_next;
    logic [OFM_DW-1:0]       word_next;
    logic                    take, emit;

    // Inputs are dropped while done and in the cycle of a layer restart.
    assign in_vld = acc_vld & ~pp_done & ~q_layer_start;

    pp_requant #(
        .ACC_W  (ACC_W),
        .BIAS_W (BIAS_W)
    ) u_requant (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (q_layer_start),
        .shift    (q_shift),
        .act_en   (q_act_en),
        .in_vld   (in_vld),
        .in_data  (acc_data),
        .in_bias  (acc_bias),
        .in_last  (acc_last),
        .out_vld  (rq_vld),
        .out_data (rq_data),
        .out_last (rq_last)
    );

    // Results still in flight when done rises are discarded.
    assign take       = rq_vld & ~pp_done;
    assign emit       = take & ((lane_cnt == 2'd3) | rq_last);
    assign frame_next = frame_cnt + 1'b1;

    // Lane register is zeroed after every emission, so lanes above the
    // current one already read 0 on a last-flushed word.
    always_comb begin
        word_next = lane_reg;
        word_next[{lane_cnt, 3'b000} +: LANE_W] = rq_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lane_reg    <= '0;
            lane_cnt    <= '0;
            word_cnt    <= '0;
            frame_cnt   <= '0;
            pp_data_vld <= 1'b0;
            pp_data     <= '0;
            pp_addr     <= '0;
            pp_done     <= 1'b0;
        end else if (q_layer_start) begin
            lane_reg    <= '0;
            lane_cnt    <= '0;
            word_cnt    <= '0;
            frame_cnt   <= '0;
            pp_data_vld <= 1'b0;
            pp_done     <= 1'b0;
        end else begin
            pp_data_vld <= 1'b0;
            if (emit) begin
                pp_data_vld <= 1'b1;
                pp_data     <= word_next;
                pp_addr     <= word_cnt;
                lane_reg    <= '0;
                lane_cnt    <= '0;
                word_cnt    <= word_cnt + 1'b1;
                frame_cnt   <= frame_next;
                if (frame_next == q_frame_size) begin
                    pp_done <= 1'b1;
                end
            end else if (take) begin
                lane_reg <= word_next;
                lane_cnt <= lane_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire
